// File: rtl/my_pkg.sv
// Shared types and constants for the data-memory stage: fault codes, RV32I
// load/store funct3 encodings, and the sub-word load extension helper.
package my_pkg;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10,
    FAULT_ILLEGAL  = 2'b11
  } mem_fault_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LSU_LANE_W = 8;
  localparam int LSU_LANES  = 4;

  // Picks the addressed lane out of a RAM word and sign/zero-extends it.
  function automatic logic [31:0] load_ext(input logic [31:0] word,
                                           input logic [1:0]  off,
                                           input logic [2:0]  f3);
    logic [LSU_LANE_W-1:0]   b;
    logic [2*LSU_LANE_W-1:0] h;
    logic [31:0]             r;
    b = word[{off, 3'b000} +: LSU_LANE_W];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_BU:   r = {24'b0, b};
      F3_HU:   r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_be_ram.sv
// Single-port synchronous data RAM with per-byte write enables and a
// registered read port; the read register holds when no read is requested.
module dmem_be_ram
  import my_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                 i_clk,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [LSU_LANES-1:0] i_we,
  input  logic                 i_re,
  input  logic [31:0]          i_wdata,
  output logic [31:0]          o_rdata
);

  logic [31:0] r_mem [0:(2**ADDR_W)-1];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < LSU_LANES; i++) begin
      if (i_we[i]) begin
        r_mem[i_addr][i*LSU_LANE_W +: LSU_LANE_W] <= i_wdata[i*LSU_LANE_W +: LSU_LANE_W];
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/flip_flop.sv
// Generic enabled register with asynchronous active-low reset.
module flip_flop #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/mem_stage_be.sv
// RV32I data-memory stage: byte-lane stores, extended sub-word loads, fault
// classification, saturating access counters and a sticky store watchpoint.
module mem_stage_be
  import my_pkg::*;
#(
  parameter int                ADDR_W     = 10,
  parameter logic [ADDR_W-1:0] WATCH_ADDR = ADDR_W'('h038),
  parameter logic [31:0]       WATCH_DATA = 32'h0000_0002,
  parameter int                CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              EN,
  input  logic              START,
  input  logic              TB_LOAD_DATA_CTRL,
  input  logic [ADDR_W-1:0] TB_LOAD_DATA_ADDR,
  input  logic [31:0]       TB_LOAD_DATA_DATA,
  input  logic [31:0]       MEM_in_ALU_res,
  input  logic [31:0]       MEM_in_reg_data_2,
  input  logic [2:0]        MEM_in_funct3,
  input  logic              MEM_in_MemRead,
  input  logic              MEM_in_MemWrite,
  input  logic [31:0]       MEM_in_instr,
  output logic [31:0]       MEM_mem_data,
  output logic [1:0]        MEM_fault,
  output logic [31:0]       WB_out_instr,
  output logic              OK,
  output logic [CNT_W-1:0]  ld_cnt,
  output logic [CNT_W-1:0]  st_cnt
);

  logic                 w_pre;
  logic                 w_act;
  logic                 w_req;
  logic [1:0]           w_off;
  logic [ADDR_W-1:0]    w_waddr;
  logic                 w_oor;
  logic                 w_illegal;
  logic                 w_misal;
  mem_fault_e           w_fault;
  logic [LSU_LANES-1:0] w_be;
  logic [31:0]          w_st_data;
  logic                 w_st_ok;
  logic                 w_ld_ok;
  logic [ADDR_W-1:0]    w_ram_addr;
  logic [LSU_LANES-1:0] w_ram_we;
  logic [31:0]          w_ram_wdata;
  logic [31:0]          w_ram_rdata;

  mem_fault_e           r_fault;
  logic                 r_ld_ok;
  logic [1:0]           r_off;
  logic [2:0]           r_f3;
  logic                 r_ok;
  logic [CNT_W-1:0]     r_ld_cnt;
  logic [CNT_W-1:0]     r_st_cnt;

  // Preload outranks the pipeline; a pipeline access needs EN and START.
  assign w_pre   = TB_LOAD_DATA_CTRL;
  assign w_act   = !w_pre && EN && START;
  assign w_req   = MEM_in_MemRead || MEM_in_MemWrite;
  assign w_off   = MEM_in_ALU_res[1:0];
  assign w_waddr = MEM_in_ALU_res[ADDR_W+1:2];
  assign w_oor   = |MEM_in_ALU_res[31:ADDR_W+2];

  always_comb begin
    w_illegal = 1'b0;
    if (w_req) begin
      case (MEM_in_funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: w_illegal = 1'b0;
        default:                        w_illegal = 1'b1;
      endcase
    end
    if (MEM_in_MemWrite && (MEM_in_funct3 == F3_BU || MEM_in_funct3 == F3_HU)) begin
      w_illegal = 1'b1;
    end
    if (MEM_in_MemRead && MEM_in_MemWrite) begin
      w_illegal = 1'b1;
    end
  end

  assign w_misal = w_req && (((MEM_in_funct3[1:0] == 2'b01) && w_off[0]) ||
                             ((MEM_in_funct3 == F3_W) && (w_off != 2'b00)));

  always_comb begin
    w_fault = FAULT_NONE;
    if (w_illegal) begin
      w_fault = FAULT_ILLEGAL;
    end else if (w_misal) begin
      w_fault = FAULT_MISALIGN;
    end else if (w_req && w_oor) begin
      w_fault = FAULT_RANGE;
    end
  end

  always_comb begin
    w_be      = '0;
    w_st_data = MEM_in_reg_data_2;
    case (MEM_in_funct3)
      F3_B: begin
        w_be      = 4'b0001 << w_off;
        w_st_data = {4{MEM_in_reg_data_2[7:0]}};
      end
      F3_H: begin
        w_be      = 4'b0011 << w_off;
        w_st_data = {2{MEM_in_reg_data_2[15:0]}};
      end
      F3_W:    w_be = 4'b1111;
      default: w_be = '0;
    endcase
  end

  assign w_st_ok = w_act && MEM_in_MemWrite && (w_fault == FAULT_NONE);
  assign w_ld_ok = w_act && MEM_in_MemRead && (w_fault == FAULT_NONE);

  assign w_ram_addr  = w_pre ? TB_LOAD_DATA_ADDR : w_waddr;
  assign w_ram_we    = w_pre ? 4'b1111 : (w_st_ok ? w_be : 4'b0000);
  assign w_ram_wdata = w_pre ? TB_LOAD_DATA_DATA : w_st_data;

  dmem_be_ram #(.ADDR_W(ADDR_W)) u_ram (
    .i_clk   (CLK),
    .i_addr  (w_ram_addr),
    .i_we    (w_ram_we),
    .i_re    (w_ld_ok),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Lane select, size and fault travel with the synchronous read so the
  // extended result and its fault code appear together one cycle later.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_fault  <= FAULT_NONE;
      r_ld_ok  <= 1'b0;
      r_off    <= 2'b00;
      r_f3     <= 3'b000;
      r_ok     <= 1'b0;
      r_ld_cnt <= '0;
      r_st_cnt <= '0;
    end else begin
      if (w_act) begin
        r_fault <= w_fault;
        r_ld_ok <= w_ld_ok;
        r_off   <= w_off;
        r_f3    <= MEM_in_funct3;
      end
      if (w_ld_ok && !(&r_ld_cnt)) begin
        r_ld_cnt <= r_ld_cnt + CNT_W'(1);
      end
      if (w_st_ok && !(&r_st_cnt)) begin
        r_st_cnt <= r_st_cnt + CNT_W'(1);
      end
      if (w_st_ok && (MEM_in_funct3 == F3_W) && (w_waddr == WATCH_ADDR) &&
          (MEM_in_reg_data_2 == WATCH_DATA)) begin
        r_ok <= 1'b1;
      end
    end
  end

  flip_flop #(.W(32)) u_instr_ff (
    .i_clk   (CLK),
    .i_rst_n (RSTn),
    .i_en    (EN && START),
    .i_d     (MEM_in_instr),
    .o_q     (WB_out_instr)
  );

  assign MEM_mem_data = r_ld_ok ? load_ext(w_ram_rdata, r_off, r_f3) : 32'h0;
  assign MEM_fault    = r_fault;
  assign OK           = r_ok;
  assign ld_cnt       = r_ld_cnt;
  assign st_cnt       = r_st_cnt;

endmodule

// File: tb/tb_mem_stage_be.sv
// Bench for mem_stage_be: byte-addressed reference model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_mem_stage_be;
  import my_pkg::*;

  localparam int          ADDR_W     = 10;
  localparam int          CNT_W      = 16;
  localparam int          MEM_BYTES  = 4 * (2 ** ADDR_W);
  localparam int          WATCH_WORD = 'h038;
  localparam logic [31:0] WATCH_VAL  = 32'h0000_0002;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              start;
  logic              tb_ctrl;
  logic [ADDR_W-1:0] tb_addr;
  logic [31:0]       tb_data;
  logic [31:0]       alu_res;
  logic [31:0]       rs2;
  logic [2:0]        f3;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       instr;
  logic [31:0]       mem_data;
  logic [1:0]        fault;
  logic [31:0]       wb_instr;
  logic              ok;
  logic [CNT_W-1:0]  ld_cnt;
  logic [CNT_W-1:0]  st_cnt;

  mem_stage_be #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .CLK               (clk),
    .RSTn              (rst_n),
    .EN                (en),
    .START             (start),
    .TB_LOAD_DATA_CTRL (tb_ctrl),
    .TB_LOAD_DATA_ADDR (tb_addr),
    .TB_LOAD_DATA_DATA (tb_data),
    .MEM_in_ALU_res    (alu_res),
    .MEM_in_reg_data_2 (rs2),
    .MEM_in_funct3     (f3),
    .MEM_in_MemRead    (mem_read),
    .MEM_in_MemWrite   (mem_write),
    .MEM_in_instr      (instr),
    .MEM_mem_data      (mem_data),
    .MEM_fault         (fault),
    .WB_out_instr      (wb_instr),
    .OK                (ok),
    .ld_cnt            (ld_cnt),
    .st_cnt            (st_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_chk  = 0;
  int          n_fail = 0;
  logic        chk_en = 1'b0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (byte-addressed memory) ----------------
  logic [7:0]       m_bytes [0:MEM_BYTES-1];
  logic [31:0]      e_data;
  logic [1:0]       e_fault;
  logic [31:0]      e_instr;
  logic             e_ok;
  logic [CNT_W-1:0] e_ld;
  logic [CNT_W-1:0] e_st;

  function automatic int acc_size(input logic [2:0] fn);
    case (fn)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [1:0] model_fault(input logic [31:0] a, input logic [2:0] fn,
                                             input logic rd, input logic wr);
    if (!rd && !wr) return 2'd0;
    if ((rd && wr) || acc_size(fn) == 0 || (wr && fn[2])) return 2'd3;
    if ((a % acc_size(fn)) != 0) return 2'd1;
    if (a >= MEM_BYTES) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] fn);
    logic [31:0] v;
    int          n;
    n = acc_size(fn);
    v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(m_bytes[a + k]) << (8 * k));
    if (!fn[2] && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_data = 0; e_fault = 0; e_instr = 0; e_ok = 0; e_ld = 0; e_st = 0;
    end else begin
      if (tb_ctrl) begin
        for (int k = 0; k < 4; k++) m_bytes[int'(tb_addr) * 4 + k] = tb_data[8*k +: 8];
      end
      if (en && start) e_instr = instr;
      if (!tb_ctrl && en && start) begin
        e_fault = model_fault(alu_res, f3, mem_read, mem_write);
        e_data  = 32'h0;
        if (e_fault == 2'd0 && mem_write) begin
          for (int k = 0; k < acc_size(f3); k++) m_bytes[alu_res + k] = rs2[8*k +: 8];
          if (e_st != '1) e_st = e_st + 1'b1;
          if (acc_size(f3) == 4 && (alu_res >> 2) == WATCH_WORD && rs2 == WATCH_VAL) e_ok = 1'b1;
        end
        if (e_fault == 2'd0 && mem_read) begin
          e_data = model_load(alu_res, f3);
          if (e_ld != '1) e_ld = e_ld + 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_mem_data", mem_data, e_data);
      chk("cyc_fault", 32'(fault), 32'(e_fault));
      chk("cyc_wb_instr", wb_instr, e_instr);
      chk("cyc_ok", 32'(ok), 32'(e_ok));
      chk("cyc_ld_cnt", 32'(ld_cnt), 32'(e_ld));
      chk("cyc_st_cnt", 32'(st_cnt), 32'(e_st));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic acc(input logic rd, input logic wr, input logic [2:0] fn,
                     input logic [31:0] addr, input logic [31:0] d, input logic [31:0] ins);
    tb_ctrl = 1'b0; en = 1'b1; start = 1'b1;
    mem_read = rd; mem_write = wr; f3 = fn; alu_res = addr; rs2 = d; instr = ins;
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    tb_ctrl = 1'b1; tb_addr = a; tb_data = d;
    en = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    tb_ctrl = 1'b0;
  endtask

  task automatic idle();
    acc(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic ld_lit(input string name, input logic [2:0] fn, input logic [31:0] addr,
                        input logic [31:0] lit);
    exp_q.push_back(lit);
    acc(1'b1, 1'b0, fn, addr, 32'h0, 32'h0);
    chk(name, mem_data, exp_q.pop_front());
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_data"}, mem_data, 32'h0);
    chk({tag, "_fault"}, 32'(fault), 32'h0);
    chk({tag, "_wb_instr"}, wb_instr, 32'h0);
    chk({tag, "_ok"}, 32'(ok), 32'h0);
    chk({tag, "_ld_cnt"}, 32'(ld_cnt), 32'h0);
    chk({tag, "_st_cnt"}, 32'(st_cnt), 32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int guard;
    rst_n = 1'b0; en = 1'b0; start = 1'b0; tb_ctrl = 1'b0; tb_addr = '0; tb_data = '0;
    alu_res = '0; rs2 = '0; f3 = '0; mem_read = 1'b0; mem_write = 1'b0; instr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk_en = 1'b1;
    rst_n = 1'b1;

    // Preloaded word, sub-word loads
    preload(10'd5, 32'h8081_7F80);
    ld_lit("lb_0x14",  F3_B,  32'h14, 32'hFFFF_FF80);
    ld_lit("lbu_0x15", F3_BU, 32'h15, 32'h0000_007F);
    ld_lit("lh_0x16",  F3_H,  32'h16, 32'hFFFF_8081);
    ld_lit("lhu_0x16", F3_HU, 32'h16, 32'h0000_8081);
    chk("ld_cnt_4", 32'(ld_cnt), 32'd4);

    // Byte and halfword stores
    preload(10'd0, 32'h0);
    acc(1'b0, 1'b1, F3_B, 32'h3, 32'h0000_00AB, 32'h0);
    acc(1'b0, 1'b1, F3_H, 32'h0, 32'h0000_1234, 32'h0);
    ld_lit("lw_0x0", F3_W, 32'h0, 32'hAB00_1234);
    chk("st_cnt_2", 32'(st_cnt), 32'd2);

    // Faults
    acc(1'b1, 1'b0, F3_W, 32'h2, 32'h0, 32'h0);
    chk("fault_lw_misal", 32'(fault), 32'h1);
    chk("fault_lw_misal_data", mem_data, 32'h0);
    acc(1'b0, 1'b1, F3_H, 32'h1, 32'h0000_FFFF, 32'h0);
    chk("fault_sh_misal", 32'(fault), 32'h1);
    acc(1'b1, 1'b0, F3_W, 32'h1 << (ADDR_W + 2), 32'h0, 32'h0);
    chk("fault_oor", 32'(fault), 32'h2);
    acc(1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0);
    chk("fault_f3_011", 32'(fault), 32'h3);
    acc(1'b1, 1'b1, F3_W, 32'h0, 32'h0, 32'h0);
    chk("fault_rd_wr", 32'(fault), 32'h3);
    chk("fault_ld_cnt", 32'(ld_cnt), 32'd5);
    chk("fault_st_cnt", 32'(st_cnt), 32'd2);
    ld_lit("ram_after_sh_fault", F3_W, 32'h0, 32'hAB00_1234);

    // Watchpoint
    acc(1'b0, 1'b1, F3_B, 32'hE0, 32'h0000_0002, 32'h0);
    idle();
    chk("ok_after_sb", 32'(ok), 32'h0);
    acc(1'b0, 1'b1, F3_W, 32'hE0, 32'h0000_0002, 32'h0);
    chk("ok_after_sw", 32'(ok), 32'h1);
    chk("st_cnt_4", 32'(st_cnt), 32'd4);
    ld_lit("lw_watch", F3_W, 32'hE0, 32'h0000_0002);
    idle();
    chk("ok_sticky", 32'(ok), 32'h1);

    // Stall
    acc(1'b1, 1'b0, F3_W, 32'h0, 32'h0, 32'h1111_1111);
    chk("stall_pre_data", mem_data, 32'hAB00_1234);
    chk("stall_pre_instr", wb_instr, 32'h1111_1111);
    tb_ctrl = 1'b0; en = 1'b0; start = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    f3 = F3_W; alu_res = 32'h14; instr = 32'h2222_2222;
    @(posedge clk); #1;
    chk("stall_en_data", mem_data, 32'hAB00_1234);
    chk("stall_en_instr", wb_instr, 32'h1111_1111);
    en = 1'b1; start = 1'b0; alu_res = 32'h2;
    @(posedge clk); #1;
    chk("stall_start_data", mem_data, 32'hAB00_1234);
    chk("stall_start_fault", 32'(fault), 32'h0);
    chk("stall_ld_cnt", 32'(ld_cnt), 32'd8);

    // Preload beats a simultaneous pipeline store
    preload(10'd8, 32'h0);
    tb_ctrl = 1'b1; tb_addr = 10'd7; tb_data = 32'hCAFE_F00D;
    en = 1'b1; start = 1'b1; mem_read = 1'b0; mem_write = 1'b1;
    f3 = F3_W; alu_res = 32'h20; rs2 = 32'h1234_5678; instr = 32'h3333_3333;
    @(posedge clk); #1;
    tb_ctrl = 1'b0;
    chk("prio_st_cnt", 32'(st_cnt), 32'd4);
    ld_lit("prio_preload_word", F3_W, 32'h1C, 32'hCAFE_F00D);
    ld_lit("prio_sw_dropped", F3_W, 32'h20, 32'h0);

    // Load counter saturation
    guard = 0;
    while (e_ld != '1 && guard < 70000) begin
      acc(1'b1, 1'b0, F3_W, 32'h1C, 32'h0, 32'h0);
      guard++;
    end
    chk("sat_reached", 32'(ld_cnt), 32'h0000_FFFF);
    acc(1'b1, 1'b0, F3_W, 32'h1C, 32'h0, 32'h0);
    chk("sat_hold", 32'(ld_cnt), 32'h0000_FFFF);

    // Asynchronous reset in the middle of an access
    tb_ctrl = 1'b0; en = 1'b1; start = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    f3 = F3_W; alu_res = 32'h1C; instr = 32'h4444_4444;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
    chk("ok_after_reset", 32'(ok), 32'h0);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
